muldiv_unit: RTL and testbench

Iterative HI/LO multiply/divide unit for the 5-stage MIPS pipeline, replacing the single-cycle product computed in the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU from EX, runs a radix-2 shift-add or restoring-divide sequence, and owns the HI/LO architectural registers, including MTHI/MTLO writes. The hazard logic stalls MFHI/MFLO in ID while `busy` is high; EX flush cancels an in-flight operation.

---
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 HI/LO multiply/divide unit with MTHI/MTLO writes.
// Define MULDIV_DIV_EN to include the restoring divider; otherwise DIV/DIVU complete as no-ops.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_next, prod;
  logic [WIDTH-1:0] opb_q, opb_d, hi_q, hi_d, lo_q, lo_d, ma, mb;
  logic [WIDTH:0] mul_sum;
  logic neg_q, neg_d, done_q, done_d, abort, accept;
`ifdef MULDIV_DIV_EN
  logic div_q, div_d, rneg_q, rneg_d;
  logic [WIDTH:0] div_sh, div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0] quo, rem;
`endif
  assign ma = (!op[0] && a[WIDTH-1]) ? -a : a;
  assign mb = (!op[0] && b[WIDTH-1]) ? -b : b;
  assign abort = flush | hi_we | lo_we;
  assign accept = (state_q == IDLE) && start && !abort;
  // acc holds {partial product, remaining multiplier bits}; shifts right each step
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign prod = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
  // acc holds {remainder, dividend bits shifting out / quotient bits shifting in}
  assign div_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign quo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    opb_d = opb_q;
    neg_d = neg_q;
    hi_d = hi_we ? wdata : hi_q;
    lo_d = lo_we ? wdata : lo_q;
    done_d = 1'b0;
`ifdef MULDIV_DIV_EN
    div_d = div_q;
    rneg_d = rneg_q;
`endif
    if (abort) begin
      state_d = IDLE;
    end else if (accept) begin
      cnt_d = '0;
`ifdef MULDIV_DIV_EN
      state_d = CALC;
      div_d = op[1];
      acc_d = {{WIDTH{1'b0}}, op[1] ? ma : mb};
      opb_d = op[1] ? mb : ma;
      // a zero divisor yields all-ones quotient with no sign fix
      neg_d = !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]) && (!op[1] || (|b));
      rneg_d = !op[0] && a[WIDTH-1];
`else
      state_d = op[1] ? IDLE : CALC;
      done_d = op[1];
      acc_d = {{WIDTH{1'b0}}, mb};
      opb_d = ma;
      neg_d = !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
    end else if (state_q == CALC) begin
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == LAST) ? FIN : CALC;
`ifdef MULDIV_DIV_EN
      acc_d = div_q ? div_next : mul_next;
`else
      acc_d = mul_next;
`endif
    end else if (state_q == FIN) begin
      state_d = IDLE;
      done_d = 1'b1;
`ifdef MULDIV_DIV_EN
      hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
      lo_d = div_q ? quo : prod[WIDTH-1:0];
`else
      hi_d = prod[2*WIDTH-1:WIDTH];
      lo_d = prod[WIDTH-1:0];
`endif
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      neg_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q <= 1'b0;
      rneg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      opb_q <= opb_d;
      neg_q <= neg_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
`ifdef MULDIV_DIV_EN
      div_q <= div_d;
      rneg_q <= rneg_d;
`endif
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit; expected HI/LO pushed at launch, popped on done.
module tb_muldiv_unit;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0] op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic busy, done;
  logic [31:0] hi, lo;
  logic [31:0] mhi = '0, mlo = '0;
  logic [63:0] sb[$];
  int errors = 0, checks = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    case (o)
      2'b00: p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
      2'b01: p = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 32'd0) p = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) p = {32'd0, 32'h80000000};
        else p = {32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y))};
      end
      default: p = (y == 32'd0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
    endcase
    return p;
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    r = model(o, x, y);
    if (o[1] && !DIV_EN) r = {mhi, mlo};
    {mhi, mlo} = r;
    sb.push_back(r);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int bc);
    edges = -1;
    bc = 0;
    for (int i = 0; i < 100; i++) begin
      bc += int'(busy);
      if (done) begin
        edges = i;
        break;
      end
      tick();
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int e, bc, exp_n;
    logic [63:0] r;
    exp_n = (o[1] && !DIV_EN) ? 0 : 33;
    launch(o, x, y);
    wait_done(e, bc);
    checks++;
    if (e !== exp_n) begin errors++; $display("FAIL latency op=%0d a=%h b=%h: got %0d expected %0d", o, x, y, e, exp_n); end
    checks++;
    if (bc !== exp_n) begin errors++; $display("FAIL busy_cycles op=%0d: got %0d expected %0d", o, bc, exp_n); end
    r = sb.pop_front();
    checks++;
    if (hi !== r[63:32]) begin errors++; $display("FAIL hi op=%0d a=%h b=%h: got %h expected %h", o, x, y, hi, r[63:32]); end
    checks++;
    if (lo !== r[31:0]) begin errors++; $display("FAIL lo op=%0d a=%h b=%h: got %h expected %h", o, x, y, lo, r[31:0]); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse op=%0d: got %b expected 0", o, done); end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    tick();
    tick();
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", lo); end
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    do_op(2'b01, 32'hFFFFFFFF, 32'd2);
    do_op(2'b00, 32'hFFFFFFFD, 32'd5);
    do_op(2'b00, 32'h80000000, 32'h80000000);
    for (int i = 0; i < 3; i++) do_op(2'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic test_div();
    do_op(2'b10, 32'hFFFFFFF9, 32'd2);
    do_op(2'b11, 32'd7, 32'd0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF);
    do_op(2'b10, 32'hFFFFFFF9, 32'd0);
    do_op(2'b11, 32'hDEADBEEF, 32'd1000);
  endtask

  task automatic test_flush();
    int seen;
    start = 1'b1; op = 2'b01; a = 32'h1111; b = 32'h2222;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd6;
    tick();
    start = 1'b0;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
    if (hi !== mhi) begin errors++; $display("FAIL flush_hi: got %h expected %h", hi, mhi); end
    if (lo !== mlo) begin errors++; $display("FAIL flush_lo: got %h expected %h", lo, mlo); end
    seen = 0;
    repeat (40) begin tick(); seen += int'(done | busy); end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d active cycles expected 0", seen); end
    start = 1'b1; flush = 1'b1; op = 2'b01;
    tick();
    start = 1'b0; flush = 1'b0;
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL flush_start_done: got %b expected 0", done); end
  endtask

  task automatic test_mthilo();
    int seen;
    start = 1'b1; op = 2'b01; a = 32'd11; b = 32'd13;
    tick();
    start = 1'b0;
    repeat (3) tick();
    lo_we = 1'b1; wdata = 32'h1234;
    tick();
    lo_we = 1'b0;
    mlo = 32'h1234;
    checks += 3;
    if (lo !== mlo) begin errors++; $display("FAIL mtlo_calc_lo: got %h expected %h", lo, mlo); end
    if (hi !== mhi) begin errors++; $display("FAIL mtlo_calc_hi: got %h expected %h", hi, mhi); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_calc_busy: got %b expected 0", busy); end
    seen = 0;
    repeat (40) begin tick(); seen += int'(done); end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mtlo_no_done: got %0d expected 0", seen); end
    start = 1'b1; op = 2'b01; a = 32'h10; b = 32'h10;
    tick();
    start = 1'b0;
    repeat (32) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL fin_busy: got %b expected 1", busy); end
    hi_we = 1'b1; wdata = 32'hCAFEF00D;
    tick();
    hi_we = 1'b0;
    mhi = 32'hCAFEF00D;
    checks += 4;
    if (hi !== mhi) begin errors++; $display("FAIL fin_write_hi: got %h expected %h", hi, mhi); end
    if (lo !== mlo) begin errors++; $display("FAIL fin_write_lo: got %h expected %h", lo, mlo); end
    if (done !== 1'b0) begin errors++; $display("FAIL fin_write_done: got %b expected 0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL fin_write_busy: got %b expected 0", busy); end
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2; hi_we = 1'b1; wdata = 32'h55;
    tick();
    start = 1'b0; hi_we = 1'b0;
    mhi = 32'h55;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL mthi_idle_busy: got %b expected 0", busy); end
    if (hi !== mhi) begin errors++; $display("FAIL mthi_idle_hi: got %h expected %h", hi, mhi); end
    if (lo !== mlo) begin errors++; $display("FAIL mthi_idle_lo: got %h expected %h", lo, mlo); end
  endtask

  task automatic test_back_to_back();
    int e, bc;
    logic [63:0] r;
    launch(2'b01, 32'h12345678, 32'h9ABCDEF0);
    wait_done(e, bc);
    r = sb.pop_front();
    checks += 2;
    if (e !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 33", e); end
    if ({hi, lo} !== r) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", {hi, lo}, r); end
    launch(2'b00, 32'hDEADBEEF, 32'd7);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", busy); end
    wait_done(e, bc);
    r = sb.pop_front();
    checks += 2;
    if (e !== 33) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 33", e); end
    if ({hi, lo} !== r) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", {hi, lo}, r); end
    tick();
  endtask

  task automatic test_async_reset();
    start = 1'b1; op = 2'b01; a = 32'hFFFF; b = 32'hFFFF;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b0;
    #1;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL arst_done: got %b expected 0", done); end
    if (hi !== 32'd0) begin errors++; $display("FAIL arst_hi: got %h expected 0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL arst_lo: got %h expected 0", lo); end
    @(posedge clk);
    #2 rst = 1'b1;
    mhi = '0;
    mlo = '0;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL arst_idle: got %b expected 0", busy); end
    do_op(2'b01, 32'd3, 32'd3);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_mthilo();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
